enc_8b10b_tx: RTL and testbench
===============================

Name: enc_8b10b_tx

Overview:
- Registered 8b/10b encoder with running-disparity (RD) tracking, K-character validation and optional idle (K28.5 comma) insertion.
- Transmit-side counterpart of the team's 8b/10b decoder.
- Its 10-bit output feeds the decoder's datain directly, so encoder-to-decoder loopback works with no bit remapping.

Parameters:
- IDLE_CHAR, 8'hBC, byte sent as a K character during idle insertion (K28.5).
- RD_RESET, 1'b0, running disparity after reset (0 = negative, 1 = positive).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- ena  input  1  encode datain/kin this cycle.
- idle_ins  input  1  when ena=0, emit IDLE_CHAR as a K character.
- datain  input  8  byte HGFEDCBA; [4:0]=EDCBA (5b/6b), [7:5]=HGF (3b/4b).
- kin  input  1  datain is a control (K) character.
- rdforce  input  1  use rdin instead of internal RD as the starting disparity for this symbol.
- rdin  input  1  forced starting RD (0 = negative, 1 = positive).
- valid  output  1  dataout holds a newly encoded symbol.
- dataout  output  10  code group; bit0=a, 1=b, 2=c, 3=d, 4=e, 5=i, 6=f, 7=g, 8=h, 9=j.
- kerr  output  1  kin=1 with a byte that is not a legal K code.
- rdout  output  1  RD after the symbol on dataout.

Behaviour:
- Reset (async, active-high) values: dataout=10'h000, valid=0, kerr=0, rdout=RD_RESET; internal RD=RD_RESET. Reset asserted mid-stream clears everything immediately. The first symbol after release uses RD_RESET.
- Latency: 1 cycle. Inputs sampled at edge N appear on the outputs after edge N; one symbol per cycle, no backpressure.
- Cycle selection:
  - ena=1: encode datain/kin.
  - ena=0 and idle_ins=1: encode IDLE_CHAR with kin=1.
  - ena=0 and idle_ins=0: valid=0; dataout, kerr, rdout and RD hold.
- Starting RD: rdin when rdforce=1, else internal RD. rdforce applies only on cycles that encode a symbol.
- 5b/6b stage: standard IEEE 802.3 table indexed by EDCBA. Use the RD- column when starting RD=0, the RD+ column otherwise.
  - A 6b sub-block with unequal ones/zeros flips RD.
  - 000111 and 111000 are neutral but still select by RD.
  - K28 uses 001111 (RD-) / 110000 (RD+).
- 3b/4b stage: indexed by HGF, using the RD after the 6b sub-block.
  - Data x.7 uses the alternate A7 encoding (0111 at RD-, 1000 at RD+) when (RD- and x in {17,18,20}) or (RD+ and x in {11,13,14}); otherwise primary P7 (1110/0001).
  - K characters use K-table 4b codes. K28.1/K28.5/K28.7 take the disparity-paired 4b code, and K.7 always uses 0111/1000 form.
- Legal K codes: 8'h1C, 3C, 5C, 7C, 9C, BC, DC, FC, F7, FB, FD, FE.
  - For any other byte with kin=1: kerr=1, and the byte is encoded as the data character with the same value (RD updated normally).
  - kerr=0 on all other encoded cycles.
- rdout and internal RD = RD after the 4b sub-block. An encoded code group never has more than 6 or fewer than 4 ones.
- valid=1 exactly on cycles whose dataout was newly encoded, including idle-insert cycles.
- Simultaneous ena=1 and idle_ins=1: data wins; idle_ins is ignored.

Test Plan:
- Reset, then ena=1 kin=0 datain=8'h00 -> next cycle dataout=10'h0b9 (D0.0 RD-), valid=1, rdout=0, kerr=0.
- ena=1 kin=1 datain=8'hBC for 4 cycles from reset -> dataout 10'h17c, 10'h283, 10'h17c, 10'h283; rdout toggles 1,0,1,0.
- ena=0 idle_ins=1 for 3 cycles after reset -> 10'h17c, 10'h283, 10'h17c with valid=1. Then ena=0 idle_ins=0 -> valid=0, dataout stays 10'h17c, rdout stays 1.
- rdforce=1 rdin=1 kin=1 datain=8'hBC -> dataout=10'h283, rdout=0. Next cycle rdforce=0 with the same input -> 10'h17c.
- kin=1 datain=8'h00 -> kerr=1 and dataout equals the D0.0 code for the current RD. Follow with a legal K (8'hBC) -> kerr=0.
- Send K28.5 to reach RD+, then pulse reset for 1 cycle -> dataout=0, valid=0, rdout=0 asynchronously. Next K28.5 -> 10'h17c. Also sweep all 256 data bytes through the team's decoder in loopback and check a byte-exact match with no decoder errors.

Source files
------------

// File: rtl/enc_8b10b_tx.sv
// Registered 8b/10b encoder: 5b/6b + 3b/4b with running-disparity tracking,
// K-character validation and optional K28.5 idle insertion. One symbol per cycle.
module enc_8b10b_tx #(
    parameter logic [7:0] IDLE_CHAR = 8'hBC,
    parameter logic       RD_RESET  = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic       idle_ins,
    input  logic [7:0] datain,
    input  logic       kin,
    input  logic       rdforce,
    input  logic       rdin,
    output logic       valid,
    output logic [9:0] dataout,
    output logic       kerr,
    output logic       rdout
);

    // 6b data codes for RD- in abcdei order (MSB = a).
    function automatic logic [5:0] code6_neg(input logic [4:0] x);
        case (x)
            5'd0:  code6_neg = 6'b100111;  5'd1:  code6_neg = 6'b011101;
            5'd2:  code6_neg = 6'b101101;  5'd3:  code6_neg = 6'b110001;
            5'd4:  code6_neg = 6'b110101;  5'd5:  code6_neg = 6'b101001;
            5'd6:  code6_neg = 6'b011001;  5'd7:  code6_neg = 6'b111000;
            5'd8:  code6_neg = 6'b111001;  5'd9:  code6_neg = 6'b100101;
            5'd10: code6_neg = 6'b010101;  5'd11: code6_neg = 6'b110100;
            5'd12: code6_neg = 6'b001101;  5'd13: code6_neg = 6'b101100;
            5'd14: code6_neg = 6'b011100;  5'd15: code6_neg = 6'b010111;
            5'd16: code6_neg = 6'b011011;  5'd17: code6_neg = 6'b100011;
            5'd18: code6_neg = 6'b010011;  5'd19: code6_neg = 6'b110010;
            5'd20: code6_neg = 6'b001011;  5'd21: code6_neg = 6'b101010;
            5'd22: code6_neg = 6'b011010;  5'd23: code6_neg = 6'b111010;
            5'd24: code6_neg = 6'b110011;  5'd25: code6_neg = 6'b100110;
            5'd26: code6_neg = 6'b010110;  5'd27: code6_neg = 6'b110110;
            5'd28: code6_neg = 6'b001110;  5'd29: code6_neg = 6'b101110;
            5'd30: code6_neg = 6'b011110;  default: code6_neg = 6'b101011;
        endcase
    endfunction

    // 4b codes seen with RD- going into the 3b/4b stage, fghj order (MSB = f).
    function automatic logic [3:0] code4_neg(input logic [2:0] y, input logic is_k,
                                             input logic alt7);
        case (y)
            3'd0:    code4_neg = 4'b1011;
            3'd1:    code4_neg = is_k ? 4'b0110 : 4'b1001;
            3'd2:    code4_neg = is_k ? 4'b1010 : 4'b0101;
            3'd3:    code4_neg = 4'b1100;
            3'd4:    code4_neg = 4'b1101;
            3'd5:    code4_neg = is_k ? 4'b0101 : 4'b1010;
            3'd6:    code4_neg = is_k ? 4'b1001 : 4'b0110;
            default: code4_neg = alt7 ? 4'b0111 : 4'b1110;
        endcase
    endfunction

    logic       r_valid;
    logic [9:0] r_dataout;
    logic       r_kerr;
    logic       r_rd;

    logic       w_encode;
    logic [7:0] w_byte;
    logic       w_kreq;
    logic       w_k_legal;
    logic       w_is_k;
    logic       w_kerr;
    logic       w_rd_start;
    logic [5:0] w_6b_neg;
    logic [5:0] w_6b;
    logic       w_6b_unbal;
    logic       w_rd_mid;
    logic       w_alt7;
    logic [3:0] w_4b_neg;
    logic [3:0] w_4b;
    logic       w_4b_unbal;
    logic       w_rd_end;
    logic [9:0] w_code;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_encode   = ena | idle_ins;
        w_byte     = ena ? datain : IDLE_CHAR;
        w_kreq     = ena ? kin : 1'b1;
        w_k_legal  = (w_byte[4:0] == 5'd28) ||
                     (w_byte == 8'hF7) || (w_byte == 8'hFB) ||
                     (w_byte == 8'hFD) || (w_byte == 8'hFE);
        w_is_k     = w_kreq & w_k_legal;
        w_kerr     = w_kreq & ~w_k_legal;
        w_rd_start = rdforce ? rdin : r_rd;

        w_6b_neg   = (w_is_k && w_byte[4:0] == 5'd28) ? 6'b001111 : code6_neg(w_byte[4:0]);
        w_6b_unbal = ($countones(w_6b_neg) != 3);
        // D7 is balanced yet still alternates with RD, so it complements like an unbalanced code.
        w_6b       = (w_rd_start && (w_6b_unbal || w_6b_neg == 6'b111000)) ? ~w_6b_neg : w_6b_neg;
        w_rd_mid   = w_rd_start ^ w_6b_unbal;

        w_alt7     = w_is_k ||
                     (!w_rd_mid && (w_byte[4:0] == 5'd17 || w_byte[4:0] == 5'd18 ||
                                    w_byte[4:0] == 5'd20)) ||
                     ( w_rd_mid && (w_byte[4:0] == 5'd11 || w_byte[4:0] == 5'd13 ||
                                    w_byte[4:0] == 5'd14));
        w_4b_neg   = code4_neg(w_byte[7:5], w_is_k, w_alt7);
        w_4b_unbal = ($countones(w_4b_neg) != 2);
        // K codes always take the complementary column at RD+, neutral ones included.
        w_4b       = (w_rd_mid && (w_is_k || w_4b_unbal || w_4b_neg == 4'b1100)) ? ~w_4b_neg : w_4b_neg;
        w_rd_end   = w_rd_mid ^ w_4b_unbal;

        w_code     = '0;
        for (int i = 0; i < 6; i++) w_code[i]     = w_6b[5-i];
        for (int i = 0; i < 4; i++) w_code[6 + i] = w_4b[3-i];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_dataout <= '0;
            r_kerr    <= 1'b0;
            r_rd      <= RD_RESET;
        end else begin
            r_valid <= w_encode;
            if (w_encode) begin
                r_dataout <= w_code;
                r_kerr    <= w_kerr;
                r_rd      <= w_rd_end;
            end
        end
    end

    assign valid   = r_valid;
    assign dataout = r_dataout;
    assign kerr    = r_kerr;
    assign rdout   = r_rd;

endmodule

// File: tb/tb_enc_8b10b_tx.sv
// Scoreboard bench for enc_8b10b_tx: directed hand-computed code groups plus a
// 256-byte sweep at each forced RD checking weight, disparity and decodability.
module tb_enc_8b10b_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       ena, idle_ins, kin, rdforce, rdin;
    logic [7:0] datain;
    logic       valid, kerr, rdout;
    logic [9:0] dataout;

    enc_8b10b_tx dut (
        .clk(clk), .reset(reset), .ena(ena), .idle_ins(idle_ins),
        .datain(datain), .kin(kin), .rdforce(rdforce), .rdin(rdin),
        .valid(valid), .dataout(dataout), .kerr(kerr), .rdout(rdout)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         exact;
        logic [9:0] code;
        logic       rd;
        logic       kerr;
        logic       start;
        logic [7:0] byt;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_x;
    int   errors = 0;
    int   checks = 0;
    int   owner[1024];
    int   ones;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [9:0] code, input logic rd, input logic ke,
                                input string name);
        exp_t x;
        x.exact = 1'b1; x.code = code; x.rd = rd; x.kerr = ke;
        x.start = 1'b0; x.byt = 8'h00; x.name = name;
        return x;
    endfunction

    function automatic exp_t mkp(input logic start, input logic [7:0] b);
        exp_t x;
        x.exact = 1'b0; x.code = '0; x.rd = 1'b0; x.kerr = 1'b0;
        x.start = start; x.byt = b; x.name = "sweep";
        return x;
    endfunction

    task automatic send(input logic e, input logic ii, input logic [7:0] d, input logic k,
                        input logic rf, input logic ri, input exp_t x);
        @(negedge clk);
        ena = e; idle_ins = ii; datain = d; kin = k; rdforce = rf; rdin = ri;
        if (e || ii) exp_q.push_back(x);
    endtask

    task automatic quiet();
        @(negedge clk);
        ena = 1'b0; idle_ins = 1'b0; kin = 1'b0; rdforce = 1'b0; rdin = 1'b0; datain = 8'h00;
    endtask

    // Reset is raised between edges so the check below proves it acts without a clock.
    task automatic do_reset(input string tag);
        @(negedge clk);
        ena = 1'b0; idle_ins = 1'b0; kin = 1'b0; rdforce = 1'b0; rdin = 1'b0;
        #2 reset = 1'b1;
        #1;
        check({tag, "_dataout"}, 32'(dataout), 32'h000);
        check({tag, "_valid"},   32'(valid),   32'h0);
        check({tag, "_kerr"},    32'(kerr),    32'h0);
        check({tag, "_rdout"},   32'(rdout),   32'h0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset && valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got dataout 0x%0h with nothing expected", dataout);
            end else begin
                mon_x = exp_q.pop_front();
                if (mon_x.exact) begin
                    check({mon_x.name, "_dataout"}, 32'(dataout), 32'(mon_x.code));
                    check({mon_x.name, "_rdout"},   32'(rdout),   32'(mon_x.rd));
                    check({mon_x.name, "_kerr"},    32'(kerr),    32'(mon_x.kerr));
                end else begin
                    ones = $countones(dataout);
                    check("sweep_weight", 32'(ones >= 4 && ones <= 6), 32'h1);
                    check("sweep_direction",
                          32'(mon_x.start ? (ones <= 5) : (ones >= 5)), 32'h1);
                    check("sweep_rdout", 32'(rdout), 32'(mon_x.start ^ (ones != 5)));
                    check("sweep_kerr", 32'(kerr), 32'h0);
                    check("sweep_unique",
                          32'(owner[dataout] == 0 || owner[dataout] == int'(mon_x.byt) + 1), 32'h1);
                    owner[dataout] = int'(mon_x.byt) + 1;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: run did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 1024; i++) owner[i] = 0;
        reset = 1'b1; ena = 1'b0; idle_ins = 1'b0; datain = 8'h00;
        kin = 1'b0; rdforce = 1'b0; rdin = 1'b0;
        @(negedge clk);
        check("por_dataout", 32'(dataout), 32'h000);
        check("por_valid",   32'(valid),   32'h0);
        check("por_kerr",    32'(kerr),    32'h0);
        check("por_rdout",   32'(rdout),   32'h0);
        reset = 1'b0;

        send(1, 0, 8'h00, 0, 0, 0, mk(10'h0b9, 0, 0, "d0_0_first"));

        do_reset("rst_a");
        send(1, 0, 8'hBC, 1, 0, 0, mk(10'h17c, 1, 0, "k28_5_a"));
        send(1, 0, 8'hBC, 1, 0, 0, mk(10'h283, 0, 0, "k28_5_b"));
        send(1, 0, 8'hBC, 1, 0, 0, mk(10'h17c, 1, 0, "k28_5_c"));
        send(1, 0, 8'hBC, 1, 0, 0, mk(10'h283, 0, 0, "k28_5_d"));

        do_reset("rst_b");
        send(0, 1, 8'h00, 0, 0, 0, mk(10'h17c, 1, 0, "idle_a"));
        send(0, 1, 8'h00, 0, 0, 0, mk(10'h283, 0, 0, "idle_b"));
        send(0, 1, 8'h00, 0, 0, 0, mk(10'h17c, 1, 0, "idle_c"));
        quiet();
        @(negedge clk);
        check("hold_valid",   32'(valid),   32'h0);
        check("hold_dataout", 32'(dataout), 32'h17c);
        check("hold_rdout",   32'(rdout),   32'h1);
        check("hold_kerr",    32'(kerr),    32'h0);

        do_reset("rst_c");
        send(1, 0, 8'hBC, 1, 1, 1, mk(10'h283, 0, 0, "rdforce_pos"));
        send(1, 0, 8'hBC, 1, 0, 0, mk(10'h17c, 1, 0, "rdforce_off"));
        send(1, 0, 8'h00, 1, 0, 0, mk(10'h346, 1, 1, "kerr_d0_0"));
        send(1, 0, 8'hBC, 1, 0, 0, mk(10'h283, 0, 0, "kerr_clear"));

        send(1, 0, 8'h00, 0, 1, 1, mk(10'h346, 1, 0, "d0_0_pos"));
        send(1, 0, 8'hB5, 0, 1, 0, mk(10'h155, 0, 0, "d21_5_neg"));
        send(1, 0, 8'hB5, 0, 1, 1, mk(10'h155, 1, 0, "d21_5_pos"));
        send(1, 0, 8'h63, 0, 1, 0, mk(10'h0e3, 0, 0, "d3_3_neg"));
        send(1, 0, 8'h63, 0, 1, 1, mk(10'h323, 1, 0, "d3_3_pos"));
        send(1, 0, 8'hE7, 0, 1, 0, mk(10'h1c7, 1, 0, "d7_7_neg"));
        send(1, 0, 8'hE7, 0, 1, 1, mk(10'h238, 0, 0, "d7_7_pos"));
        send(1, 0, 8'hF1, 0, 1, 0, mk(10'h3b1, 1, 0, "d17_7_alt"));
        send(1, 0, 8'hEB, 0, 1, 1, mk(10'h04b, 0, 0, "d11_7_alt"));
        send(1, 0, 8'hFC, 1, 1, 0, mk(10'h07c, 0, 0, "k28_7"));
        send(1, 0, 8'hF7, 1, 1, 0, mk(10'h057, 0, 0, "k23_7"));
        send(1, 1, 8'h00, 0, 1, 0, mk(10'h0b9, 0, 0, "ena_beats_idle"));
        send(1, 0, 8'h1C, 1, 1, 0, mk(10'h0bc, 0, 0, "k28_0"));
        send(0, 0, 8'h00, 0, 1, 1, mk(10'h000, 0, 0, "unused"));
        send(0, 1, 8'h00, 0, 0, 0, mk(10'h17c, 1, 0, "rdforce_ignored_on_hold"));

        for (int r = 0; r < 2; r++)
            for (int b = 0; b < 256; b++)
                send(1, 0, 8'(b), 0, 1, 1'(r), mkp(1'(r), 8'(b)));

        do_reset("rst_d");
        send(1, 0, 8'hBC, 1, 0, 0, mk(10'h17c, 1, 0, "pre_midreset"));
        quiet();
        do_reset("rst_mid");
        send(1, 0, 8'hBC, 1, 0, 0, mk(10'h17c, 1, 0, "post_midreset"));
        quiet();
        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
